// File: rtl/gpio_ctrl.sv
// GPIO pad-bank controller: bus-mapped OUT/DIR/PULLEN registers, synchronised pad
// inputs and per-bit edge detection feeding a sticky W1C status with a level irq.
module gpio_ctrl #(
   parameter int unsigned N_GPIO      = 25,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_addr,
   input  logic [N_GPIO-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [N_GPIO-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [N_GPIO-1:0] gpio_out,
   output logic [N_GPIO-1:0] gpio_dir,
   output logic [N_GPIO-1:0] gpio_pullen,
   input  logic [N_GPIO-1:0] gpio_in,
   output logic              irq
);

   typedef enum logic [2:0] {
      AddrOut, AddrDir, AddrPullen, AddrIn, AddrRiseEn, AddrFallEn, AddrStatus, AddrUnmapped
   } addr_e;

   logic [N_GPIO-1:0] out_q, out_d, dir_q, dir_d, pullen_q, pullen_d;
   logic [N_GPIO-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d, status_q, status_d;
   logic [N_GPIO-1:0] rsp_rdata_q, rsp_rdata_d, prev_q, sync, w1c, rd_sel, rise, fall;
   logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_q;
   logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, irq_q, accept;

   assign sync      = sync_q[SYNC_STAGES-1];
   assign req_ready = ~rsp_valid_q | rsp_ready;
   assign accept    = req_valid & req_ready;

   always_comb begin
      out_d     = out_q;
      dir_d     = dir_q;
      pullen_d  = pullen_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c       = '0;
      rd_sel    = '0;

      // Read mux sees pre-update state so a read-modify-write in one cycle is coherent
      case (addr_e'(req_addr))
         AddrOut:      rd_sel = out_q;
         AddrDir:      rd_sel = dir_q;
         AddrPullen:   rd_sel = pullen_q;
         AddrIn:       rd_sel = sync;
         AddrRiseEn:   rd_sel = rise_en_q;
         AddrFallEn:   rd_sel = fall_en_q;
         AddrStatus:   rd_sel = status_q;
         AddrUnmapped: rd_sel = '0;
         default:      rd_sel = '0;
      endcase

      if (accept && req_write) begin
         case (addr_e'(req_addr))
            AddrOut:    out_d     = req_wdata;
            AddrDir:    dir_d     = req_wdata;
            AddrPullen: pullen_d  = req_wdata;
            AddrRiseEn: rise_en_d = req_wdata;
            AddrFallEn: fall_en_d = req_wdata;
            AddrStatus: w1c       = req_wdata;
            default:    ;
         endcase
      end

      rise     = sync & ~prev_q & dir_q & rise_en_q;
      fall     = ~sync & prev_q & dir_q & fall_en_q;
      status_d = (status_q & ~w1c) | rise | fall;

      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = req_write ? '0 : rd_sel;
         rsp_err_d   = (addr_e'(req_addr) == AddrUnmapped);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         dir_q       <= '1;
         pullen_q    <= '0;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         status_q    <= '0;
         sync_q      <= '0;
         prev_q      <= '0;
         irq_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         out_q       <= out_d;
         dir_q       <= dir_d;
         pullen_q    <= pullen_d;
         rise_en_q   <= rise_en_d;
         fall_en_q   <= fall_en_d;
         status_q    <= status_d;
         sync_q      <= {sync_q[SYNC_STAGES-2:0], gpio_in};
         prev_q      <= sync;
         irq_q       <= |status_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign gpio_out    = out_q;
   assign gpio_dir    = dir_q;
   assign gpio_pullen = pullen_q;
   assign irq         = irq_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;

endmodule
